// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control and strobe bundle for the programmable clock divider.
// The master side (host/peripheral) drives the enable and divisor writes; the
// slave side (clk_div_prog) returns the status and the generated strobes.
// Optional macro CLK_DIV_SYNC_EN adds the sync_i realignment input.
// CNT_W here must match the CNT_W of the attached clk_div_prog.
interface clk_div_prog_if #(
    parameter int CNT_W = 16
);
    logic             en_i;
    logic             div_wr_i;
    logic [CNT_W-1:0] div_in_i;
`ifdef CLK_DIV_SYNC_EN
    logic             sync_i;
`endif
    logic             div_busy_o;
    logic             div_err_o;
    logic             ovs_tick_o;
    logic             tick_o;
    logic             new_clk_o;

`ifdef CLK_DIV_SYNC_EN
    modport master (
        output en_i, div_wr_i, div_in_i, sync_i,
        input  div_busy_o, div_err_o, ovs_tick_o, tick_o, new_clk_o
    );
    modport slave (
        input  en_i, div_wr_i, div_in_i, sync_i,
        output div_busy_o, div_err_o, ovs_tick_o, tick_o, new_clk_o
    );
`else
    modport master (
        output en_i, div_wr_i, div_in_i,
        input  div_busy_o, div_err_o, ovs_tick_o, tick_o, new_clk_o
    );
    modport slave (
        input  en_i, div_wr_i, div_in_i,
        output div_busy_o, div_err_o, ovs_tick_o, tick_o, new_clk_o
    );
`endif
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock/baud divider.
// Produces an oversample strobe every div cycles, an output-rate strobe every
// div*OVS cycles and a 50% duty divided clock of period div*OVS. Divisor writes
// made while running are staged and applied only at a base-counter wrap, so no
// shortened (runt) interval is ever produced.
// Optional macro CLK_DIV_SYNC_EN: adds sync_i, which realigns the counters to a
// half output period (UART RX start-bit centring).
module clk_div_prog #(
    parameter int IN_FREQ  = 50000000,
    parameter int OUT_FREQ = 9600,
    parameter int OVS      = 16,
    parameter int CNT_W    = 16,
    parameter int DIV_DEF  = (IN_FREQ + OUT_FREQ * OVS / 2) / (OUT_FREQ * OVS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    clk_div_prog_if.slave bus
);
    localparam int                 OVS_W       = $clog2(OVS);
    localparam logic [CNT_W-1:0]   DIV_RST     = CNT_W'(DIV_DEF);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   DIV_MIN     = CNT_W'(2);
    localparam logic [OVS_W-1:0]   OVS_ONE     = OVS_W'(1);
    localparam logic [OVS_W-1:0]   OVS_LAST    = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0]   OVS_HALF_M1 = OVS_W'(OVS / 2 - 1);
`ifdef CLK_DIV_SYNC_EN
    localparam logic [OVS_W-1:0]   OVS_HALF    = OVS_W'(OVS / 2);
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
    logic             ovs_tick_q, ovs_tick_d;
    logic             tick_q, tick_d;
    logic             new_clk_q, new_clk_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] div_m1;
    logic             wrap;
    logic             wr_ok;

    assign div_m1 = div_q - CNT_ONE;
    assign wrap   = bus.en_i && (cnt_q == div_m1);
    assign wr_ok  = bus.div_wr_i && (bus.div_in_i >= DIV_MIN);

    // Next-state logic: counters, staged divisor and registered strobes.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        ovs_cnt_d  = ovs_cnt_q;
        ovs_tick_d = 1'b0;
        tick_d     = 1'b0;
        new_clk_d  = new_clk_q;
        err_d      = bus.div_wr_i && (bus.div_in_i < DIV_MIN);

        if (!bus.en_i) begin
            // Idle: counters parked, outputs low; divisor writes take effect directly.
            cnt_d     = '0;
            ovs_cnt_d = '0;
            new_clk_d = 1'b0;
            if (busy_q) begin
                div_d  = pend_q;
                busy_d = 1'b0;
            end
            if (wr_ok) begin
                div_d = bus.div_in_i;
            end
        end
`ifdef CLK_DIV_SYNC_EN
        else if (bus.sync_i) begin
            // Realign: next tick lands half an output period from here.
            cnt_d     = '0;
            ovs_cnt_d = OVS_HALF;
            new_clk_d = 1'b0;
            if (busy_q) begin
                div_d  = pend_q;
                busy_d = 1'b0;
            end
            if (wr_ok) begin
                pend_d = bus.div_in_i;
                busy_d = 1'b1;
            end
        end
`endif
        else begin
            if (wrap) begin
                cnt_d      = '0;
                ovs_tick_d = 1'b1;
                // A staged divisor only ever starts on a fresh interval.
                if (busy_q) begin
                    div_d  = pend_q;
                    busy_d = 1'b0;
                end
                if (ovs_cnt_q == OVS_LAST) begin
                    ovs_cnt_d = '0;
                    tick_d    = 1'b1;
                    new_clk_d = 1'b1;
                end else begin
                    ovs_cnt_d = ovs_cnt_q + OVS_ONE;
                    if (ovs_cnt_q == OVS_HALF_M1) begin
                        new_clk_d = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            // Staging after the wrap handling defers a coincident write one interval.
            if (wr_ok) begin
                pend_d = bus.div_in_i;
                busy_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset to the default divisor.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_q     <= '0;
            busy_q     <= 1'b0;
            ovs_cnt_q  <= '0;
            ovs_tick_q <= 1'b0;
            tick_q     <= 1'b0;
            new_clk_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            ovs_cnt_q  <= ovs_cnt_d;
            ovs_tick_q <= ovs_tick_d;
            tick_q     <= tick_d;
            new_clk_q  <= new_clk_d;
            err_q      <= err_d;
        end
    end

    assign bus.div_busy_o = busy_q;
    assign bus.div_err_o  = err_q;
    assign bus.ovs_tick_o = ovs_tick_q;
    assign bus.tick_o     = tick_q;
    assign bus.new_clk_o  = new_clk_q;
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock/baud divider, the parametrised successor to the fixed clk_div. It produces three outputs from the system clock:
- a single-cycle oversample strobe
- a single-cycle output-rate strobe
- a 50%-duty divided clock
The divisor is reloadable at run time without glitches. It sits between the system clock and serial peripherals (UART TX/RX, SPI); the default divisor is derived from IN_FREQ/OUT_FREQ.

Parameters:
IN_FREQ, 50000000, input clock frequency in Hz
OUT_FREQ, 9600, default output rate in Hz
OVS, 16, oversample factor; even, >=2
CNT_W, 16, divisor/counter width in bits
DIV_DEF, (IN_FREQ+OUT_FREQ*OVS/2)/(OUT_FREQ*OVS), reset divisor, rounded to nearest (326 for defaults)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  run enable
div_wr  in  1  divisor write strobe, one cycle
div_in  in  CNT_W  new divisor value
div_busy  out  1  written divisor pending, not yet applied
div_err  out  1  one-cycle pulse: rejected write (div_in<2)
ovs_tick  out  1  one-cycle strobe every div clk cycles
tick  out  1  one-cycle strobe every div*OVS clk cycles
new_clk  out  1  divided clock, period div*OVS, 50% duty

Behaviour:
- Reset (rst=0, async):
  - Internal state: div=DIV_DEF, cnt=0, ovs_cnt=0, pending clear.
  - Outputs: all outputs 0.
- Base counter:
  - en=1: cnt counts 0..div-1 and wraps.
  - ovs_tick is registered and asserts for one cycle on the cycle after cnt==div-1.
- Oversample counter:
  - ovs_cnt counts 0..OVS-1 on each internal wrap event.
  - tick asserts for one cycle together with the ovs_tick that completes ovs_cnt==OVS-1.
- new_clk, registered:
  - Rises coincident with tick.
  - Falls coincident with the ovs_tick that completes ovs_cnt==OVS/2-1.
  - High for div*OVS/2 cycles, low for div*OVS/2 cycles.
- First tick after en rises: exactly div*OVS cycles after the first enabled cycle.
- en=0:
  - cnt and ovs_cnt clear to 0 synchronously.
  - ovs_tick, tick and new_clk forced to 0 on the next edge.
  - div is retained.
- Divisor write, div_wr=1:
  - div_in<2: div_err pulses the next cycle; no other state changes.
  - div_in>=2 with en=0: div loads next edge; div_busy stays 0.
  - div_in>=2 with en=1: value is staged and div_busy=1. It is applied at the next cnt wrap (same edge cnt returns to 0); div_busy clears on that edge. ovs_cnt is not disturbed.
- Write while div_busy=1: staged value is overwritten (last write wins); application point unchanged.
- Write on the same cycle as a wrap: the new value is staged and applies at the following wrap, not the current one.
- Width: div_in, div and cnt are CNT_W bits, unsigned. The maximum divisor is 2^CNT_W-1.
- Reset mid-operation discards any staged divisor and returns div to DIV_DEF.

Optional Feature:
CLK_DIV_SYNC_EN
- Defined:
  - Adds input port sync (1 bit), for UART RX start-bit realignment.
  - sync=1 with en=1: cnt<=0 and ovs_cnt<=OVS/2, so the next tick lands half an output period later, mid-bit.
  - new_clk<=0 on the same edge; no strobe in that cycle.
  - sync has priority over a coincident wrap; a pending divisor is applied on the sync edge.
  - sync with en=0: ignored.
- Undefined: no sync port; counters run free.

Test Plan:
1. Reset/defaults: hold rst=0 10 cycles -> all outputs 0. Release with en=1, defaults -> ovs_tick period 326 cycles; tick and new_clk period 5216; new_clk high 2608 cycles.
2. Program while idle (OVS=4): en=0, write div_in=5, then en=1 -> div_busy never set; first tick at cycle 20; ovs_tick every 5; new_clk high 10/low 10.
3. Glitch-free reload (OVS=4): running at div=5, write 3 mid-count -> div_busy=1 until next wrap. Current 5-cycle interval completes; subsequent ovs_tick spacing 3; no runt strobe.
4. Invalid/overwrite: write div_in=1 -> div_err one cycle, div unchanged. Write 7 then 9 before the wrap -> 9 applied, single div_busy clear.
5. Enable/reset abort: drop en mid-period -> outputs 0 next edge; re-enable -> full period restarts. Assert rst with a divisor staged -> div returns to DIV_DEF, div_busy=0.
6. (CLK_DIV_SYNC_EN; div=4, OVS=16) pulse sync -> next tick exactly 32 cycles later; new_clk 0 then resumes 64-cycle period.
